// File: rtl/fifo_pkg.sv
// fifo_pkg: shared defaults and Gray/binary helpers for both FIFO controllers.
// Rev 1.0
`default_nettype none

package fifo_pkg;

  localparam int FIFO_DATASIZE = 8;
  localparam int FIFO_ADDRSIZE = 4;

  // Operands are zero-extended pointers; callers truncate the result to ADDRSIZE+1 bits.
  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 1; i < 32; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-side memory, pointer-exchange and output-stream signals.
// Rev 1.0
`default_nettype none

interface fifo_rd_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATASIZE = FIFO_DATASIZE,
  parameter int ADDRSIZE = FIFO_ADDRSIZE
) ();

  logic [ADDRSIZE:0]   rq2_wptr;
  logic [DATASIZE-1:0] rdata;
  logic [ADDRSIZE-1:0] raddr;
  logic [ADDRSIZE:0]   rptr;
  logic                rempty;
  logic                raempty;
  logic [ADDRSIZE:0]   rcount;
  logic [DATASIZE-1:0] dout;
  logic                dout_valid;
  logic                dout_ready;

  modport master (
    input  rq2_wptr, rdata, dout_ready,
    output raddr, rptr, rempty, raempty, rcount, dout, dout_valid
  );

  modport slave (
    output rq2_wptr, rdata, dout_ready,
    input  raddr, rptr, rempty, raempty, rcount, dout, dout_valid
  );

endinterface

`default_nettype wire

// File: rtl/fifo_gray2bin.sv
// fifo_gray2bin: combinational Gray-to-binary converter (XOR of all bits at or above each position).
// Rev 1.0
`default_nettype none

module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async-FIFO read controller with Gray pointer, flags, fill level and FWFT output register.
// Rev 1.0
`default_nettype none

module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int DATASIZE      = FIFO_DATASIZE,
  parameter int ADDRSIZE      = FIFO_ADDRSIZE,
  parameter int AEMPTY_THRESH = 2
) (
  input logic            rclk,
  input logic            rrst,
  fifo_rd_ctrl_if.master bus
);

  localparam int              PTRW       = ADDRSIZE + 1;
  localparam logic [PTRW-1:0] AEMPTY_LVL = PTRW'(AEMPTY_THRESH);

  logic [PTRW-1:0]     rbin_q, rbin_d;
  logic [PTRW-1:0]     rptr_q, rptr_d;
  logic [PTRW-1:0]     rcount_q, rcount_d;
  logic                rempty_q, rempty_d;
  logic [DATASIZE-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic [PTRW-1:0]     wbin;
  logic                rinc;

  fifo_gray2bin #(.W(PTRW)) u_wptr_g2b (
    .gray_i (bus.rq2_wptr),
    .bin_o  (wbin)
  );

  always_comb begin
    rinc         = !rempty_q && (!dout_valid_q || bus.dout_ready);
    rbin_d       = rbin_q + PTRW'(rinc);
    rptr_d       = PTRW'(bin2gray(32'(rbin_d)));
    rempty_d     = (rptr_d == bus.rq2_wptr);
    // Fill level is taken against the post-pop pointer so it already reflects this edge's read.
    rcount_d     = wbin - rbin_d;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (rinc) begin
      dout_d       = bus.rdata;
      dout_valid_d = 1'b1;
    end else if (bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_q       <= '0;
      rptr_q       <= '0;
      rcount_q     <= '0;
      rempty_q     <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rcount_q     <= rcount_d;
      rempty_q     <= rempty_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.raddr      = rbin_q[ADDRSIZE-1:0];
  assign bus.rptr       = rptr_q;
  assign bus.rempty     = rempty_q;
  assign bus.raempty    = (rcount_q <= AEMPTY_LVL);
  assign bus.rcount     = rcount_q;
  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: scoreboard bench for the FIFO read controller with a word-count reference model.
// Rev 1.0
`default_nettype none

module tb_fifo_rd_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int AE    = 2;

  logic clk  = 1'b0;
  logic rrst = 1'b1;
  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.DATASIZE(DW), .ADDRSIZE(AW)) bus ();

  fifo_rd_ctrl #(.DATASIZE(DW), .ADDRSIZE(AW), .AEMPTY_THRESH(AE)) dut (
    .rclk (clk),
    .rrst (rrst),
    .bus  (bus)
  );

  logic [DW-1:0] mem [DEPTH];
  assign bus.rdata = mem[bus.raddr];

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sb [$];
  logic [PW-1:0] wbin  = '0;
  logic [PW-1:0] acc   = '0;
  logic [PW-1:0] wseen = '0;
  logic [PW-1:0] mon_rbin, mon_cnt;
  bit            was_rst = 1'b1;

  function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic bit space_ok();
    logic [PW-1:0] used;
    used = wbin - acc;
    return used < 5'd16;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writer model: one word into memory, pointer published as Gray, expectation queued.
  task automatic push(input logic [DW-1:0] d);
    int guard;
    guard = 0;
    while (!space_ok()) begin
      tick();
      guard++;
      if (guard > 200) begin
        checks++;
        errors++;
        $display("FAIL push_timeout: got no space expected space within 200 cycles");
        return;
      end
    end
    mem[wbin[AW-1:0]] = d;
    sb.push_back(d);
    wbin = wbin + 1'b1;
    bus.rq2_wptr = gray(wbin);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    bus.dout_ready = 1'b1;
    while ((sb.size() != 0 || bus.dout_valid) && guard < 200) begin
      tick();
      guard++;
    end
    check("drain_done", {31'd0, (sb.size() == 0 && !bus.dout_valid)}, 32'd1);
  endtask

  // Monitor: rbin equals words accepted plus the one held in dout; fill is written minus read.
  always @(negedge clk) begin
    if (rrst) begin
      acc     = '0;
      sb.delete();
      was_rst = 1'b1;
    end else begin
      mon_rbin = acc + {{(PW-1){1'b0}}, bus.dout_valid};
      mon_cnt  = was_rst ? '0 : wseen - mon_rbin;
      check("rptr",    32'(bus.rptr),    32'(gray(mon_rbin)));
      check("raddr",   32'(bus.raddr),   32'(mon_rbin[AW-1:0]));
      check("rcount",  32'(bus.rcount),  32'(mon_cnt));
      check("rempty",  32'(bus.rempty),  32'(mon_cnt == '0));
      check("raempty", 32'(bus.raempty), 32'(mon_cnt <= 5'(AE)));
      if (bus.dout_valid && bus.dout_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected no word", bus.dout);
        end else begin
          check("dout", 32'(bus.dout), 32'(sb.pop_front()));
        end
        acc = acc + 1'b1;
      end
      was_rst = 1'b0;
    end
    wseen = wbin;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish, checks %0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PW-1:0] base;
    int            n;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    bus.dout_ready = 1'b0;
    bus.rq2_wptr   = '0;

    // Reset state
    tick();
    tick();
    check("rst_rempty",  32'(bus.rempty),     32'd1);
    check("rst_raempty", 32'(bus.raempty),    32'd1);
    check("rst_rcount",  32'(bus.rcount),     32'd0);
    check("rst_valid",   32'(bus.dout_valid), 32'd0);
    check("rst_dout",    32'(bus.dout),       32'd0);
    check("rst_rptr",    32'(bus.rptr),       32'd0);
    rrst = 1'b0;
    tick();
    tick();

    // Single word latency
    push(8'hA5);
    tick();
    check("single_rempty_n1", 32'(bus.rempty),     32'd0);
    check("single_valid_n1",  32'(bus.dout_valid), 32'd0);
    tick();
    check("single_valid_n2",  32'(bus.dout_valid), 32'd1);
    check("single_dout_n2",   32'(bus.dout),       32'hA5);
    check("single_rptr_n2",   32'(bus.rptr),       32'd1);
    check("single_rempty_n2", 32'(bus.rempty),     32'd1);
    bus.dout_ready = 1'b1;
    tick();
    bus.dout_ready = 1'b0;
    tick();

    // Streaming at one word per cycle
    bus.dout_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
    tick();
    tick();
    for (int i = 0; i < 8; i++) begin
      check("stream_valid", 32'(bus.dout_valid), 32'd1);
      check("stream_data",  32'(bus.dout),       32'(8'h10 + i));
      tick();
    end
    check("stream_end_valid",  32'(bus.dout_valid), 32'd0);
    check("stream_end_rcount", 32'(bus.rcount),     32'd0);

    // Backpressure: head word holds, exactly one pop
    bus.dout_ready = 1'b0;
    base = wbin;
    push(8'h30);
    push(8'h31);
    push(8'h32);
    repeat (5) tick();
    check("bp_valid",   32'(bus.dout_valid), 32'd1);
    check("bp_dout",    32'(bus.dout),       32'h30);
    check("bp_rcount",  32'(bus.rcount),     32'd2);
    check("bp_raempty", 32'(bus.raempty),    32'd1);
    check("bp_rptr",    32'(bus.rptr),       32'(gray(base + 1'b1)));
    drain();

    // Randomized traffic and backpressure
    for (int c = 0; c < 1500; c++) begin
      bus.dout_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 2) == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) begin
          if (space_ok()) push(8'($urandom));
        end
      end
      tick();
    end
    drain();

    // Full and pointer wrap from rbin = 28
    n = int'(5'(5'd28 - wbin));
    for (int k = 0; k < n; k++) push(8'($urandom));
    drain();
    tick();
    check("prewrap_rptr", 32'(bus.rptr), 32'(gray(5'd28)));
    bus.dout_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) push(8'(8'h40 + k));
    tick();
    check("full_rcount",  32'(bus.rcount),  32'd16);
    check("full_rempty",  32'(bus.rempty),  32'd0);
    check("full_raempty", 32'(bus.raempty), 32'd0);
    check("full_raddr",   32'(bus.raddr),   32'd12);
    drain();
    check("wrap_rptr",   32'(bus.rptr),   32'b01010);
    check("wrap_rcount", 32'(bus.rcount), 32'd0);

    // Reset while streaming
    bus.dout_ready = 1'b1;
    for (int k = 0; k < 8; k++) push(8'(8'h80 + k));
    tick();
    tick();
    check("mid_pre_valid", 32'(bus.dout_valid), 32'd1);
    rrst         = 1'b1;
    wbin         = '0;
    bus.rq2_wptr = '0;
    tick();
    check("mid_valid",  32'(bus.dout_valid), 32'd0);
    check("mid_rempty", 32'(bus.rempty),     32'd1);
    check("mid_rptr",   32'(bus.rptr),       32'd0);
    check("mid_rcount", 32'(bus.rcount),     32'd0);
    check("mid_dout",   32'(bus.dout),       32'd0);
    rrst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_no_emit", 32'(bus.dout_valid), 32'd0);
    end
    push(8'h5A);
    push(8'h5B);
    drain();
    tick();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_rd_ctrl.md
# fifo_rd_ctrl

Read-side controller for the asynchronous FIFO. It owns the read pointer and generates the binary address and Gray-coded pointer for the dual-clock memory and the write-domain synchronizer. It computes empty, almost-empty and fill level from the already-synchronized write pointer. It presents memory data through a registered valid/ready output stage in first-word-fall-through style.

## Interface
- DATASIZE, 8, data word width (matches memory)
- ADDRSIZE, 4, memory address bits; DEPTH = 1<<ADDRSIZE
- AEMPTY_THRESH, 2, raempty asserts when rcount <= this value
- rclk  in  1  read clock; the only clock, everything on posedge
- rrst  in  1  reset, synchronous and active-high
- rq2_wptr  in  ADDRSIZE+1  write pointer, Gray-coded, already synchronized into rclk
- rdata  in  DATASIZE  memory read data; combinational function of raddr
- raddr  out  ADDRSIZE  memory read address = rbin[ADDRSIZE-1:0]
- rptr  out  ADDRSIZE+1  registered Gray read pointer, sent to the write-domain synchronizer
- rempty  out  1  registered empty flag
- raempty  out  1  almost-empty flag
- rcount  out  ADDRSIZE+1  registered fill level seen by the reader, 0..DEPTH
- dout  out  DATASIZE  output data register
- dout_valid  out  1  dout holds an unconsumed word
- dout_ready  in  1  consumer accepts dout when dout_valid && dout_ready

## Operation
- State: rbin (ADDRSIZE+1-bit binary), rptr (Gray of rbin), rempty, rcount, dout, dout_valid.
- Pop rule: rinc = !rempty && (!dout_valid || dout_ready).
  - On rinc: dout <= rdata, dout_valid <= 1, and rbin advances.
  - On accept without rinc: dout_valid <= 0 and dout holds its value.
- Next-state values:
  - rbinnext = rbin + rinc, modulo 2^(ADDRSIZE+1).
  - rgraynext = (rbinnext>>1) ^ rbinnext.
  - rptr <= rgraynext.
  - rempty <= (rgraynext == rq2_wptr).
  - rcount <= gray2bin(rq2_wptr) - rbinnext, modulo 2^(ADDRSIZE+1).
- raempty = (rcount <= AEMPTY_THRESH); it is combinational from registered rcount.
- Reset values: rbin = 0, rptr = 0, rempty = 1, rcount = 0, dout = 0, dout_valid = 0. raempty is therefore 1 out of reset.
- Wrap-around: the pointer wraps from 2^(ADDRSIZE+1)-1 to 0. The MSB toggles on each lap, so rcount = DEPTH (full) is distinct from 0 (empty).
- Simultaneous accept and pop gives back-to-back delivery: the new word replaces the consumed one in the same edge, at 1 word/cycle sustained.
- Empty with dout_valid=1 and no accept: dout holds and no pop occurs.
- A stale rq2_wptr (synchronizer lag) only delays deassertion of rempty. It never produces a false non-empty, so underflow is impossible by construction.
- Reset mid-operation returns all state to reset values on the next edge. A word held in dout is discarded. The write domain must be reset in the same system reset sequence.

## Timing
- rq2_wptr changes at edge N, making the FIFO non-empty:
  - rempty = 0 after edge N+1.
  - dout_valid = 1 with the first word after edge N+2.
- rptr reflects a pop on the same edge that loads dout.
- rcount lags rq2_wptr by one edge and reflects pops on that edge.
- Read path latency: raddr to rdata is combinational within one rclk cycle. dout is registered, so there is no combinational path from rdata to the consumer.

## Structure
- Package fifo_pkg:
  - default DATASIZE/ADDRSIZE localparams;
  - functions bin2gray and gray2bin, parameterized by width through the ADDRSIZE+1 convention.
  - The write-side controller reuses this package.
- One sub-module, fifo_gray2bin: the combinational XOR-prefix converter of width ADDRSIZE+1 used for rcount.
- The synchronizer stays outside this block.

## Test plan
- Reset: assert rrst for 2 cycles with rq2_wptr=0 -> rempty=1, raempty=1, rcount=0, dout_valid=0, dout=0, rptr=0.
- Single word: memory[0]=0xA5; step rq2_wptr 0->1 (Gray 00001) at edge N -> rempty=0 at N+1, dout=0xA5 and dout_valid=1 at N+2, rptr=00001, rempty=1 at N+2.
- Streaming: rq2_wptr=Gray(8), memory[i]=i+0x10, dout_ready=1 -> dout 0x10..0x17 on 8 consecutive cycles, then dout_valid=0, rcount=0.
- Backpressure: FIFO holds 3 words, dout_ready=0 for 5 cycles -> dout holds the first word, rbin advances exactly once, rcount=2, raempty=1.
- Full and wrap: with rbin=28, rq2_wptr=Gray(12) (DEPTH=16) -> rcount=16. Drain all 16 words -> raddr sequence 12..15,0..11, rbin wraps 31->0, rptr=Gray(12).
- Mid-stream reset: rrst during streaming with dout_valid=1 -> next edge dout_valid=0, rempty=1, rptr=0. No word is emitted until rq2_wptr advances from 0 again.
